// File: rtl/frame_mem_if.sv
// Bus bundle for the frame-buffer controller: random-access port,
// frame-clear/stream control and the raster streaming output.
interface frame_mem_if #(
    parameter int DATA_W = 1,
    parameter int X_W    = 8,
    parameter int Y_W    = 8
);
    logic [X_W-1:0]    xAddressIn;
    logic [Y_W-1:0]    yAddressIn;
    logic [DATA_W-1:0] dataIn;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] dataOut;
    logic              dataValid;
    logic              addrErr;
    logic              clearStart;
    logic              streamStart;
    logic              streamReady;
    logic [DATA_W-1:0] streamData;
    logic              streamValid;
    logic              streamLast;
    logic              busy;

    modport master (
        output xAddressIn, yAddressIn, dataIn, write, read,
        output clearStart, streamStart, streamReady,
        input  dataOut, dataValid, addrErr,
        input  streamData, streamValid, streamLast, busy
    );

    modport slave (
        input  xAddressIn, yAddressIn, dataIn, write, read,
        input  clearStart, streamStart, streamReady,
        output dataOut, dataValid, addrErr,
        output streamData, streamValid, streamLast, busy
    );
endinterface

// File: rtl/frame_mem_ctrl.sv
// Parametrised frame buffer for the median-filter datapath: bounds-checked
// random access, hardware frame clear and a raster-order stream read port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | random read/write serviced; waits for clearStart/streamStart
// ST_CLEAR  | writes CLEAR_VAL to one word per cycle, address 0..last
// ST_STREAM | fetches pixels in raster order into the output register
module frame_mem_ctrl #(
    parameter int              DATA_W    = 1,
    parameter int              IMG_W     = 240,
    parameter int              IMG_H     = 180,
    parameter int              X_W       = 8,
    parameter int              Y_W       = 8,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic       clk,
    input  logic       reset,
    frame_mem_if.slave bus
);
    localparam int DEPTH = IMG_W * IMG_H;
    localparam int A_W   = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_STREAM} state_t;

    state_t            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d, x_nxt;
    logic [Y_W-1:0]    y_q, y_d, y_nxt;
    logic [A_W-1:0]    lin_q, lin_d, lin_nxt;
    logic              fetch_done_q, fetch_done_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] strm_data_q, strm_data_d;
    logic              strm_valid_q, strm_valid_d;
    logic              strm_last_q, strm_last_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [A_W-1:0]    mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [A_W-1:0]    rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic              in_range;
    logic [A_W-1:0]    rand_addr;
    logic              x_end;
    logic              frame_end;
    logic              xfer;

    // Compare in 32 bits so an IMG_W equal to 2**X_W cannot truncate to 0.
    assign in_range  = (32'(bus.xAddressIn) < IMG_W) && (32'(bus.yAddressIn) < IMG_H);
    assign rand_addr = A_W'(bus.yAddressIn) * A_W'(IMG_W) + A_W'(bus.xAddressIn);
    assign x_end     = (x_q == X_W'(IMG_W - 1));
    assign frame_end = x_end && (y_q == Y_W'(IMG_H - 1));
    assign xfer      = strm_valid_q && bus.streamReady;
    assign rd_data   = mem_q[rd_addr];

    // Raster position advance; explicit wrap so geometry need not be a power of two.
    always_comb begin
        x_nxt   = x_end ? '0 : x_q + 1'b1;
        y_nxt   = frame_end ? '0 : (x_end ? y_q + 1'b1 : y_q);
        lin_nxt = frame_end ? '0 : lin_q + 1'b1;
    end

    // Next-state, memory port and output register computation.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        lin_d        = lin_q;
        fetch_done_d = fetch_done_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        strm_data_d  = strm_data_q;
        strm_valid_d = strm_valid_q;
        strm_last_d  = strm_last_q;
        busy_d       = busy_q;
        mem_we       = 1'b0;
        mem_waddr    = lin_q;
        mem_wdata    = CLEAR_VAL;
        rd_addr      = lin_q;

        case (state_q)
            ST_IDLE: begin
                rd_addr = in_range ? rand_addr : '0;
                if (bus.write) begin
                    if (in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = rand_addr;
                        mem_wdata = bus.dataIn;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                // Read uses the pre-edge array contents, so read+write is read-first.
                if (bus.read) begin
                    data_valid_d = 1'b1;
                    if (in_range) begin
                        data_out_d = rd_data;
                    end else begin
                        data_out_d = '0;
                        addr_err_d = 1'b1;
                    end
                end
                if (bus.clearStart) begin
                    state_d = ST_CLEAR;
                    busy_d  = 1'b1;
                end else if (bus.streamStart) begin
                    state_d      = ST_STREAM;
                    busy_d       = 1'b1;
                    fetch_done_d = 1'b0;
                end
            end

            ST_CLEAR: begin
                mem_we = 1'b1;
                x_d    = x_nxt;
                y_d    = y_nxt;
                lin_d  = lin_nxt;
                if (frame_end) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            ST_STREAM: begin
                if (xfer && strm_last_q) begin
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    strm_valid_d = 1'b0;
                    strm_last_d  = 1'b0;
                    fetch_done_d = 1'b0;
                end else if ((!strm_valid_q || bus.streamReady) && !fetch_done_q) begin
                    // Output slot is free or being consumed: refill it this edge.
                    strm_data_d  = rd_data;
                    strm_valid_d = 1'b1;
                    strm_last_d  = frame_end;
                    fetch_done_d = frame_end;
                    x_d          = x_nxt;
                    y_d          = y_nxt;
                    lin_d        = lin_nxt;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Pixel storage; deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            lin_q        <= '0;
            fetch_done_q <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            strm_data_q  <= '0;
            strm_valid_q <= 1'b0;
            strm_last_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            lin_q        <= lin_d;
            fetch_done_q <= fetch_done_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            addr_err_q   <= addr_err_d;
            strm_data_q  <= strm_data_d;
            strm_valid_q <= strm_valid_d;
            strm_last_q  <= strm_last_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.dataOut     = data_out_q;
    assign bus.dataValid   = data_valid_q;
    assign bus.addrErr     = addr_err_q;
    assign bus.streamData  = strm_data_q;
    assign bus.streamValid = strm_valid_q;
    assign bus.streamLast  = strm_last_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_frame_mem_ctrl.sv
// Directed bench for frame_mem_ctrl on a 4x3, 8-bit frame: random access,
// bounds, read-first, clear, backpressured streaming and mid-stream reset.
module tb_frame_mem_ctrl;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int X_W    = 3;
    localparam int Y_W    = 2;
    localparam int N      = IMG_W * IMG_H;
    localparam logic [7:0] CLR = 8'hA5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_mem_if #(.DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W)) bus ();

    frame_mem_ctrl #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .X_W(X_W), .Y_W(Y_W), .CLEAR_VAL(CLR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {logic [7:0] data; logic err;}  rd_exp_t;
    typedef struct packed {logic [7:0] data; logic last;} st_exp_t;

    rd_exp_t    rq[$];
    st_exp_t    sq[$];
    logic [7:0] mdl [N];
    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score a stream transfer before the edge, then read results after it.
    task automatic tick();
        logic       hold;
        logic [7:0] hold_d;
        logic       hold_l;
        st_exp_t    se;
        rd_exp_t    re;
        hold   = bus.streamValid && !bus.streamReady;
        hold_d = bus.streamData;
        hold_l = bus.streamLast;
        if (bus.streamValid && bus.streamReady) begin
            if (sq.size() == 0) begin
                chk("stream_unexpected", 32'(bus.streamValid), 32'(0));
            end else begin
                se = sq.pop_front();
                chk("stream_data", 32'(bus.streamData), 32'(se.data));
                chk("stream_last", 32'(bus.streamLast), 32'(se.last));
            end
        end
        @(posedge clk);
        #1;
        if (hold) begin
            chk("stall_valid", 32'(bus.streamValid), 32'(1));
            chk("stall_data", 32'(bus.streamData), 32'(hold_d));
            chk("stall_last", 32'(bus.streamLast), 32'(hold_l));
        end
        if (bus.dataValid) begin
            if (rq.size() == 0) begin
                chk("unexpected_dataValid", 32'(bus.dataValid), 32'(0));
            end else begin
                re = rq.pop_front();
                chk("rd_data", 32'(bus.dataOut), 32'(re.data));
                chk("rd_addrErr", 32'(bus.addrErr), 32'(re.err));
            end
        end
    endtask

    task automatic wr(int x, int y, logic [7:0] d);
        logic inr;
        inr = (x < IMG_W) && (y < IMG_H);
        bus.xAddressIn = X_W'(x);
        bus.yAddressIn = Y_W'(y);
        bus.dataIn     = d;
        bus.write      = 1'b1;
        tick();
        chk("wr_addrErr", 32'(bus.addrErr), 32'(!inr));
        bus.write = 1'b0;
        if (inr) mdl[y * IMG_W + x] = d;
    endtask

    task automatic rd(int x, int y);
        logic inr;
        inr = (x < IMG_W) && (y < IMG_H);
        bus.xAddressIn = X_W'(x);
        bus.yAddressIn = Y_W'(y);
        bus.read       = 1'b1;
        rq.push_back(inr ? rd_exp_t'{mdl[y * IMG_W + x], 1'b0} : rd_exp_t'{8'h00, 1'b1});
        tick();
        chk("rd_latency_valid", 32'(bus.dataValid), 32'(1));
        bus.read = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) sq.push_back(st_exp_t'{8'(i), (i == N - 1)});
    endtask

    task automatic chk_outputs_zero(string tag);
        chk({tag, "_dataOut"}, 32'(bus.dataOut), 32'(0));
        chk({tag, "_dataValid"}, 32'(bus.dataValid), 32'(0));
        chk({tag, "_addrErr"}, 32'(bus.addrErr), 32'(0));
        chk({tag, "_streamData"}, 32'(bus.streamData), 32'(0));
        chk({tag, "_streamValid"}, 32'(bus.streamValid), 32'(0));
        chk({tag, "_streamLast"}, 32'(bus.streamLast), 32'(0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    endtask

    initial begin
        int         n;
        int         vcnt;
        logic       sv_seen;
        logic       last_xfer;
        logic [7:0] nv;

        bus.xAddressIn  = '0;
        bus.yAddressIn  = '0;
        bus.dataIn      = '0;
        bus.write       = 1'b0;
        bus.read        = 1'b0;
        bus.clearStart  = 1'b0;
        bus.streamStart = 1'b0;
        bus.streamReady = 1'b0;

        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset = 1'b1;
        tick();

        // random fill and read-back
        for (int i = 0; i < N; i++) wr(i % IMG_W, i / IMG_W, 8'($urandom_range(0, 255)));
        for (int i = 0; i < N; i++) rd(i % IMG_W, i / IMG_W);

        // read and write together return the old word
        nv = ~mdl[5];
        bus.xAddressIn = X_W'(1);
        bus.yAddressIn = Y_W'(1);
        bus.dataIn     = nv;
        bus.write      = 1'b1;
        bus.read       = 1'b1;
        rq.push_back(rd_exp_t'{mdl[5], 1'b0});
        tick();
        chk("rw_valid", 32'(bus.dataValid), 32'(1));
        bus.write = 1'b0;
        bus.read  = 1'b0;
        mdl[5] = nv;
        rd(1, 1);

        // bounds: dropped writes, zeroed erroring reads, no aliasing
        wr(4, 0, 8'h3C);
        wr(0, 3, 8'h3C);
        wr(7, 2, 8'hC3);
        rd(3, 2);
        rd(4, 1);
        rd(0, 3);
        for (int i = 0; i < N; i++) rd(i % IMG_W, i / IMG_W);

        // stream with random backpressure
        for (int i = 0; i < N; i++) wr(i % IMG_W, i / IMG_W, 8'(i));
        push_frame();
        bus.streamStart = 1'b1;
        bus.streamReady = 1'b0;
        tick();
        bus.streamStart = 1'b0;
        chk("stream_busy_rise", 32'(bus.busy), 32'(1));
        chk("stream_first_wait", 32'(bus.streamValid), 32'(0));
        tick();
        chk("stream_first_valid", 32'(bus.streamValid), 32'(1));
        n = 0;
        while (bus.busy && n < 200) begin
            bus.streamReady = 1'($urandom_range(0, 1));
            last_xfer = bus.streamValid && bus.streamReady && bus.streamLast;
            tick();
            n++;
            if (last_xfer) chk("stream_busy_fall", 32'(bus.busy), 32'(0));
        end
        chk("stream_bp_timeout", 32'(n < 200), 32'(1));
        chk("stream_bp_drained", 32'(sq.size()), 32'(0));

        // stream at full rate
        push_frame();
        bus.streamReady = 1'b1;
        bus.streamStart = 1'b1;
        tick();
        bus.streamStart = 1'b0;
        tick();
        n = 0;
        vcnt = 0;
        while (bus.busy && n < 50) begin
            if (bus.streamValid) vcnt++;
            tick();
            n++;
        end
        chk("fullrate_valid_cycles", 32'(vcnt), 32'(N));
        chk("fullrate_busy_cycles", 32'(n), 32'(N));
        chk("fullrate_drained", 32'(sq.size()), 32'(0));

        // clear; accesses and starts during busy must be ignored
        bus.streamReady = 1'b0;
        bus.clearStart  = 1'b1;
        tick();
        bus.clearStart = 1'b0;
        n = 0;
        sv_seen = 1'b0;
        while (bus.busy && n < 100) begin
            n++;
            sv_seen = sv_seen | bus.streamValid;
            bus.xAddressIn  = '0;
            bus.yAddressIn  = '0;
            bus.dataIn      = 8'h11;
            bus.write       = 1'b1;
            bus.read        = 1'b1;
            bus.streamStart = 1'b1;
            tick();
        end
        bus.write       = 1'b0;
        bus.read        = 1'b0;
        bus.streamStart = 1'b0;
        chk("clear_busy_cycles", 32'(n), 32'(N));
        chk("clear_no_stream", 32'(sv_seen), 32'(0));

        // both starts together, issued the cycle busy falls: clear wins
        bus.clearStart  = 1'b1;
        bus.streamStart = 1'b1;
        tick();
        bus.clearStart  = 1'b0;
        bus.streamStart = 1'b0;
        chk("both_start_busy", 32'(bus.busy), 32'(1));
        n = 0;
        sv_seen = 1'b0;
        while (bus.busy && n < 100) begin
            n++;
            sv_seen = sv_seen | bus.streamValid;
            tick();
        end
        chk("both_start_clear_cycles", 32'(n), 32'(N));
        chk("both_start_no_stream", 32'(sv_seen | bus.streamValid), 32'(0));
        for (int i = 0; i < N; i++) mdl[i] = CLR;
        for (int i = 0; i < N; i++) rd(i % IMG_W, i / IMG_W);

        // reset during a stream after pixel 5
        for (int i = 0; i < N; i++) wr(i % IMG_W, i / IMG_W, 8'(i));
        push_frame();
        bus.streamReady = 1'b1;
        bus.streamStart = 1'b1;
        tick();
        bus.streamStart = 1'b0;
        n = 0;
        while (sq.size() > N - 6 && n < 50) begin
            tick();
            n++;
        end
        chk("midreset_reached", 32'(sq.size()), 32'(N - 6));
        reset = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        sq.delete();
        #3 reset = 1'b1;
        tick();
        push_frame();
        bus.streamStart = 1'b1;
        tick();
        bus.streamStart = 1'b0;
        n = 0;
        while ((bus.busy || sq.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        chk("restream_drained", 32'(sq.size()), 32'(0));
        chk("restream_idle", 32'(bus.busy), 32'(0));
        bus.streamReady = 1'b0;
        for (int i = 0; i < N; i++) rd(i % IMG_W, i / IMG_W);
        chk("rd_queue_empty", 32'(rq.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
